l2_loss_sequencer: RTL and testbench

Sequencer and accumulator for the squared-error (L2) loss datapath. It accepts a loss job of arbitrary length `total_len`, consumes prediction/target vectors in SIZE-lane chunks over a valid/ready handshake, and masks lanes beyond the job length. It accumulates the chunk sums of squared differences and returns one saturated fixed-point loss plus a done pulse. It sits between the training-loop controller (job issue) and the activation buffer streaming yHat/y.

---
 rtl/l2_pkg.sv | 13 +
 rtl/l2_chunk_sq.sv | 62 ++++++
 rtl/l2_loss_sequencer.sv | 143 ++++++++++++++
 tb/tb_l2_loss_sequencer.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/l2_pkg.sv
// Shared types and constants for the squared-error loss datapath.
package l2_pkg;

    localparam int unsigned L2_IL = 4;
    localparam int unsigned L2_FL = 16;

    typedef logic signed [L2_IL+L2_FL-1:0] fixed_t;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} l2_state_t;

    localparam fixed_t FIX_MAX = fixed_t'((1 << (L2_IL + L2_FL - 1)) - 1);

endpackage

// File: rtl/l2_chunk_sq.sv
// One chunk of masked squared differences, rescaled and summed, with a
// single registered output stage.
module l2_chunk_sq #(
    parameter int unsigned IL     = 4,
    parameter int unsigned FL     = 16,
    parameter int unsigned SIZE   = 16,
    parameter int unsigned CSUM_W = 31
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic                           valid_i,
    input  logic [SIZE-1:0]                lane_mask_i,
    input  logic [SIZE-1:0][IL+FL-1:0]     y_hat_i,
    input  logic [SIZE-1:0][IL+FL-1:0]     y_i,
    output logic                           valid_o,
    output logic [CSUM_W-1:0]              sum_o
);

    localparam int unsigned W  = IL + FL;
    localparam int unsigned DW = W + 1;
    localparam int unsigned PW = 2 * DW;
    localparam int unsigned SW = PW - FL;

    logic [SW-1:0]     lane_sq [SIZE];
    logic [CSUM_W-1:0] sum_d, sum_q;
    logic              valid_q;

    for (genvar g = 0; g < SIZE; g++) begin : g_lane
        logic signed [DW-1:0] diff;
        logic signed [PW-1:0] diff_ext;
        logic        [PW-1:0] sq;

        // One extra bit keeps the difference of two full-range operands exact.
        assign diff     = {y_hat_i[g][W-1], y_hat_i[g]} - {y_i[g][W-1], y_i[g]};
        assign diff_ext = {{(PW-DW){diff[DW-1]}}, diff};
        assign sq       = diff_ext * diff_ext;
        assign lane_sq[g] = lane_mask_i[g] ? sq[PW-1:FL] : '0;
    end

    always_comb begin
        sum_d = '0;
        for (int i = 0; i < SIZE; i++) begin
            sum_d = sum_d + {{(CSUM_W-SW){1'b0}}, lane_sq[i]};
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            valid_q <= 1'b0;
            sum_q   <= '0;
        end else begin
            valid_q <= valid_i;
            if (valid_i) begin
                sum_q <= sum_d;
            end
        end
    end

    assign valid_o = valid_q;
    assign sum_o   = sum_q;

endmodule

// File: rtl/l2_loss_sequencer.sv
// Job sequencer for the L2 loss: chunks the job, masks the tail lanes,
// accumulates chunk sums and returns a saturated fixed-point result.
module l2_loss_sequencer
    import l2_pkg::*;
#(
    parameter int unsigned IL    = L2_IL,
    parameter int unsigned FL    = L2_FL,
    parameter int unsigned SIZE  = 16,
    parameter int unsigned LEN_W = 16,
    parameter int unsigned ACC_W = 48
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        start_i,
    input  logic [LEN_W-1:0]            total_len_i,
    output logic                        busy_o,
    input  logic                        in_valid_i,
    output logic                        in_ready_o,
    input  logic [SIZE-1:0][IL+FL-1:0]  y_hat_i,
    input  logic [SIZE-1:0][IL+FL-1:0]  y_i,
    output logic                        done_o,
    output logic signed [IL+FL-1:0]     sum_o,
    output logic                        sat_o
);

    localparam int unsigned W      = IL + FL;
    localparam int unsigned CSUM_W = 2 * (W + 1) - FL + $clog2(SIZE) + 1;
    localparam logic [ACC_W-1:0] SumMax = {{(ACC_W-W+1){1'b0}}, {(W-1){1'b1}}};

    l2_state_t         state_q, state_d;
    logic [LEN_W-1:0]  remaining_q, remaining_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [W-1:0]      sum_q, sum_d;
    logic              sat_q, sat_d;

    logic              fire;
    logic              last_chunk;
    logic [LEN_W-1:0]  lanes_valid;
    logic [SIZE-1:0]   lane_mask;
    logic              chunk_valid;
    logic [CSUM_W-1:0] chunk_sum;
    logic [ACC_W:0]    acc_sum;
    logic [ACC_W-1:0]  acc_sat;

    assign fire        = in_valid_i && (state_q == RUN);
    assign last_chunk  = (remaining_q <= LEN_W'(SIZE));
    assign lanes_valid = last_chunk ? remaining_q : LEN_W'(SIZE);

    always_comb begin
        lane_mask = '0;
        for (int i = 0; i < SIZE; i++) begin
            lane_mask[i] = (LEN_W'(i) < lanes_valid);
        end
    end

    l2_chunk_sq #(
        .IL     (IL),
        .FL     (FL),
        .SIZE   (SIZE),
        .CSUM_W (CSUM_W)
    ) u_chunk_sq (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .valid_i     (fire),
        .lane_mask_i (lane_mask),
        .y_hat_i     (y_hat_i),
        .y_i         (y_i),
        .valid_o     (chunk_valid),
        .sum_o       (chunk_sum)
    );

    // A carry out of the accumulator pins it at all-ones instead of wrapping.
    assign acc_sum = {1'b0, acc_q} + {{(ACC_W+1-CSUM_W){1'b0}}, chunk_sum};
    assign acc_sat = acc_sum[ACC_W] ? '1 : acc_sum[ACC_W-1:0];

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start_i) state_d = (total_len_i == '0) ? DONE : RUN;
            RUN:     if (fire && last_chunk) state_d = DRAIN;
            DRAIN:   if (!chunk_valid) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_o     = (state_q != IDLE);
        in_ready_o = (state_q == RUN);
        done_o     = (state_q == DONE);
        sum_o      = sum_q;
        sat_o      = sat_q;
    end

    always_comb begin
        remaining_d = remaining_q;
        acc_d       = acc_q;
        sum_d       = sum_q;
        sat_d       = sat_q;
        if (state_q == IDLE && start_i) begin
            remaining_d = total_len_i;
            acc_d       = '0;
            sat_d       = 1'b0;
            if (total_len_i == '0) begin
                sum_d = '0;
            end
        end
        if (fire) begin
            remaining_d = remaining_q - lanes_valid;
        end
        if (chunk_valid) begin
            acc_d = acc_sat;
        end
        // The pipeline is empty here, so acc_q already holds the final total.
        if (state_q == DRAIN && !chunk_valid) begin
            sat_d = (acc_q > SumMax);
            sum_d = sat_d ? SumMax[W-1:0] : acc_q[W-1:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            remaining_q <= '0;
            acc_q       <= '0;
            sum_q       <= '0;
            sat_q       <= 1'b0;
        end else begin
            remaining_q <= remaining_d;
            acc_q       <= acc_d;
            sum_q       <= sum_d;
            sat_q       <= sat_d;
        end
    end

endmodule

// File: tb/tb_l2_loss_sequencer.sv
// Randomized self-checking bench for l2_loss_sequencer against an
// element-wise arithmetic model of the loss.
module tb_l2_loss_sequencer;

    localparam int unsigned IL    = 4;
    localparam int unsigned FL    = 16;
    localparam int unsigned SIZE  = 16;
    localparam int unsigned LEN_W = 16;
    localparam int unsigned ACC_W = 48;
    localparam int unsigned W     = IL + FL;
    localparam longint      MAXV  = (longint'(1) << (W - 1)) - 1;

    logic                      clk = 1'b0;
    logic                      reset;
    logic                      start;
    logic [LEN_W-1:0]          total_len;
    logic                      busy;
    logic                      in_valid;
    logic                      in_ready;
    logic [SIZE-1:0][W-1:0]    y_hat;
    logic [SIZE-1:0][W-1:0]    y;
    logic                      done;
    logic signed [W-1:0]       sum;
    logic                      sat;

    int     n_cmp = 0;
    int     n_err = 0;
    longint jyh[$];
    longint jy[$];

    always #5 clk = ~clk;

    l2_loss_sequencer #(
        .IL    (IL),
        .FL    (FL),
        .SIZE  (SIZE),
        .LEN_W (LEN_W),
        .ACC_W (ACC_W)
    ) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .start_i     (start),
        .total_len_i (total_len),
        .busy_o      (busy),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .y_hat_i     (y_hat),
        .y_i         (y),
        .done_o      (done),
        .sum_o       (sum),
        .sat_o       (sat)
    );

    task automatic check_eq(input string tag, input logic signed [63:0] obs,
                            input logic signed [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic longint model_sum(input int len);
        longint s = 0;
        for (int k = 0; k < len; k++) begin
            longint d = jyh[k] - jy[k];
            s += (d * d) >> FL;
        end
        return s;
    endfunction

    function automatic longint rand_fix(input int mag_bits);
        return longint'($urandom_range(0, (1 << mag_bits) - 1)) - (longint'(1) << (mag_bits - 1));
    endfunction

    task automatic fill_const(input int len, input longint vyh, input longint vy);
        jyh.delete();
        jy.delete();
        for (int k = 0; k < len; k++) begin
            jyh.push_back(vyh);
            jy.push_back(vy);
        end
    endtask

    task automatic fill_rand(input int len, input int mag_bits);
        jyh.delete();
        jy.delete();
        for (int k = 0; k < len; k++) begin
            jyh.push_back(rand_fix(mag_bits));
            jy.push_back(rand_fix(mag_bits));
        end
    endtask

    // Lanes past the job length get junk that must never reach the result.
    task automatic drive_chunk(input int base, input int len);
        for (int l = 0; l < SIZE; l++) begin
            int k = base + l;
            if (k < len) begin
                y_hat[l] = W'(jyh[k]);
                y[l]     = W'(jy[k]);
            end else begin
                y_hat[l] = W'(65536);
                y[l]     = W'($urandom);
            end
        end
    endtask

    task automatic run_job(input int len, input int vmode, input bit inject, input string tag);
        longint exp_sum;
        longint exp_sat;
        int     exp_x;
        int     xfers = 0;
        int     last_c = 0;
        int     cyc = 0;
        bit     done_seen = 0;
        bit     ready_late = 0;
        bit     ready_seen = 0;
        bit     injected = 0;

        exp_sum = model_sum(len);
        exp_sat = (exp_sum > MAXV) ? 1 : 0;
        if (exp_sat != 0) exp_sum = MAXV;
        exp_x = (len + SIZE - 1) / SIZE;

        start     = 1'b1;
        total_len = LEN_W'(len);
        in_valid  = 1'b0;
        step();
        while (cyc < 2000) begin
            start = 1'b0;
            if (done) begin
                done_seen = 1;
                break;
            end
            if (in_ready) ready_seen = 1;
            if (in_ready && xfers >= exp_x) ready_late = 1;
            case (vmode)
                0:       in_valid = 1'b1;
                1:       in_valid = (cyc % 4 != 1);
                default: in_valid = 1'($urandom_range(0, 1));
            endcase
            drive_chunk(xfers * SIZE, len);
            if (inject && !injected && xfers == 1 && in_ready) begin
                start     = 1'b1;
                total_len = LEN_W'(5);
                injected  = 1;
            end
            if (in_valid && in_ready) begin
                xfers++;
                last_c = cyc;
            end
            step();
            cyc++;
        end
        in_valid = 1'b0;
        check_eq({tag, ":done_seen"}, 64'(done_seen), 1);
        if (done_seen) begin
            check_eq({tag, ":sum"}, sum, exp_sum);
            check_eq({tag, ":sat"}, sat, exp_sat);
            check_eq({tag, ":xfers"}, xfers, exp_x);
            check_eq({tag, ":latency"}, cyc, (len == 0) ? 0 : last_c + 3);
            check_eq({tag, ":ready_after_last"}, 64'(ready_late), 0);
            if (len == 0) check_eq({tag, ":ready_seen"}, 64'(ready_seen), 0);
            // A start in the DONE cycle must be dropped.
            start     = 1'b1;
            total_len = LEN_W'(7);
            step();
            start = 1'b0;
            check_eq({tag, ":done_pulse"}, done, 0);
            check_eq({tag, ":busy_after"}, busy, 0);
            check_eq({tag, ":sum_held"}, sum, exp_sum);
        end
    endtask

    initial begin
        bit late_done;

        reset     = 1'b1;
        start     = 1'b0;
        total_len = '0;
        in_valid  = 1'b0;
        y_hat     = '0;
        y         = '0;
        step();
        step();
        check_eq("rst:busy", busy, 0);
        check_eq("rst:in_ready", in_ready, 0);
        check_eq("rst:done", done, 0);
        check_eq("rst:sum", sum, 0);
        check_eq("rst:sat", sat, 0);
        reset = 1'b0;
        step();

        jyh.delete();
        jy.delete();
        jyh.push_back(65536);
        jyh.push_back(131072);
        jyh.push_back(32768);
        repeat (3) jy.push_back(0);
        run_job(3, 0, 0, "partial");
        check_eq("partial:const", sum, 344064);

        fill_const(40, 16384 + 1000, 1000);
        run_job(40, 1, 0, "multi");
        check_eq("multi:const", sum, 163840);

        fill_const(16, 65536, 0);
        run_job(16, 0, 0, "sat");
        check_eq("sat:const", sum, 524287);

        fill_const(1, -65536, 65536);
        run_job(1, 0, 0, "neg");
        check_eq("neg:const", sum, 262144);

        jyh.delete();
        jy.delete();
        run_job(0, 0, 0, "zero");

        fill_const(1, 98304, 32768);
        run_job(1, 0, 0, "pre_rst");

        // Abort a job after its first chunk; nothing from it may survive.
        fill_const(40, 16384, 0);
        start     = 1'b1;
        total_len = LEN_W'(40);
        step();
        start    = 1'b0;
        in_valid = 1'b1;
        drive_chunk(0, 40);
        check_eq("abort:ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        reset    = 1'b1;
        step();
        reset = 1'b0;
        check_eq("abort:busy", busy, 0);
        check_eq("abort:in_ready", in_ready, 0);
        check_eq("abort:sum", sum, 0);
        late_done = 0;
        for (int i = 0; i < 5; i++) begin
            if (done || busy) late_done = 1;
            step();
        end
        check_eq("abort:quiet", 64'(late_done), 0);
        fill_const(1, 32768, 0);
        run_job(1, 0, 0, "post_abort");
        check_eq("post_abort:const", sum, 16384);

        fill_const(40, 16384, 0);
        run_job(40, 0, 1, "busy_start");
        check_eq("busy_start:const", sum, 163840);

        for (int t = 0; t < 24; t++) begin
            int len  = $urandom_range(0, 70);
            int mag  = $urandom_range(10, 20);
            fill_rand(len, mag);
            run_job(len, 2, t[0], $sformatf("rand%0d", t));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
